icache_2way_ro: RTL and testbench
=================================

# icache_2way_ro

Parametrised two-way set-associative, read-only instruction cache between the pipeline IF stage and the 128-bit instruction memory. It generalises our direct-mapped read-only cache with a configurable set count and address width, two ways with per-set LRU replacement, and an optional whole-cache flush. Hits return in the same cycle. Misses stall the processor while a 4-word line is fetched.

## Interface
- `ADDR_W`, default 30: processor word-address width.
- `SETS`, default 8: sets per way. Must be a power of two, ≥2. `IDX_W = log2(SETS)`, `TAG_W = ADDR_W-2-IDX_W`.
- `clk` in 1: clock.
- `proc_reset` in 1: reset. One clock; reset is synchronous and active-high.
- `proc_read` in 1: fetch request.
- `proc_write` in 1: ignored; the cache is read-only.
- `proc_addr` in ADDR_W: word address. Fields: `[1:0]` word offset, `[IDX_W+1:2]` set, upper bits tag.
- `proc_wdata` in 32: ignored.
- `proc_rdata` out 32: fetched word.
- `proc_stall` out 1: the processor must hold `proc_addr` stable while this is high.
- `mem_read` out 1: line read request.
- `mem_write` out 1: tied 0.
- `mem_addr` out ADDR_W-2: line address, `proc_addr[ADDR_W-1:2]`.
- `mem_rdata` in 128: line data; word k is in bits `[32k+31:32k]`.
- `mem_wdata` out 128: tied 0.
- `mem_ready` in 1: line valid this cycle.

## Operation
- Per way and set: valid bit, TAG_W tag, 4×32 data. Per set: one LRU bit, which names the way to evict next.
- States:
  - IDLE. If `proc_read` is low: `proc_stall`=0 and no lookup. If `proc_read` is high: compare both ways. On a hit, `proc_stall`=0, `proc_rdata` comes from the hitting way, and the set's LRU is set to the other way. On a miss, `proc_stall`=1 and the next state is FETCH.
  - FETCH. `mem_read`=1 and `mem_addr` is held. On `mem_ready`, write line, tag and valid into the victim way, set LRU to the other way, and go to FILL.
  - FILL. `proc_stall`=1, one bubble cycle, then IDLE, where the access hits.
- Victim selection: way 0 if invalid; else way 1 if invalid; else the LRU way.
- If both ways hit (an illegal state), way 0 wins.
- `proc_rdata` is 0 when there is no hit.
- `mem_ready` is ignored outside FETCH.

## Timing
- Hit: zero added latency; data is combinational in the same cycle.
- Miss: `proc_stall` is high from the miss cycle until FILL completes. Total = 1 (IDLE detect) + N (FETCH, where N counts cycles up to and including `mem_ready`) + 1 (FILL). The word is returned in the following IDLE cycle.
- `mem_read` stays high every FETCH cycle, including the `mem_ready` cycle. It falls in FILL.
- Reset values: state IDLE, all valid=0, all LRU=0, `mem_read`=0, `mem_write`=0, `mem_wdata`=0.
- While `proc_reset` is high: `proc_stall`=1 and `mem_read`=0.
- Reset during FETCH aborts the request; no line is written. A stale `mem_ready` after reset is ignored.
- A reset is no flush substitute for in-flight data: data arrays are not cleared, only valid bits.

## Configuration
- `ICACHE_FLUSH_EN` defined:
  - Adds input `proc_flush` (1 bit).
  - In IDLE, a flush clears every valid and LRU bit at the next edge, with `proc_stall`=1 for that cycle and no lookup.
  - A flush during FETCH/FILL is latched as pending. The fill completes first, then the clear is applied on the first IDLE cycle, which stalls.
- `ICACHE_FLUSH_EN` undefined: no `proc_flush` port, no pending register, and lines are invalidated only by reset.

## Structure
- Package `icache_pkg`:
  - state enum (IDLE, FETCH, FILL);
  - `WORDS_PER_LINE`=4 and `LINE_W`=128;
  - a function computing `IDX_W` from `SETS`.
- Sub-module `icache_way`, instantiated twice. It holds one way's valid/tag/data arrays and takes `SETS`/`TAG_W`. It does a combinational lookup (hit, word) and a synchronous line write with synchronous valid clear.
- The top level holds the FSM, LRU array, victim selection, flush logic and output muxing.

## Test plan
All scenarios use SETS=8 and ADDR_W=30.
- **Cold miss then hit:** after reset, read 0x10 with a memory latency of 3. Expect stall for 5 cycles, `mem_addr`=0x4, one `mem_read` burst; then `proc_rdata`= word0 of the line with stall=0, and a re-read of 0x11 hits in the same cycle with word1.
- **Two-way coexistence:** fill 0x10 (set 4, tag 0) and 0x30 (set 4, tag 1). Alternating reads of 0x10/0x30 all hit with no `mem_read`.
- **LRU eviction:** after the above, read 0x10 and then miss on 0x50 (tag 2). 0x30's way is replaced; 0x10 still hits and 0x30 then misses.
- **Idle and write ignored:** `proc_read`=0 for 10 cycles, with `proc_write`=1 and arbitrary `proc_wdata`. Expect `proc_stall`=0, `mem_read`=0 and `mem_write`=0 throughout.
- **Reset mid-FETCH:** assert `proc_reset` on the second FETCH cycle, then return `mem_ready`. Expect `mem_read` 0 the next cycle and a re-read of the same address to miss again.
- **Flush (`ICACHE_FLUSH_EN`):** fill 0x10, then pulse `proc_flush` in IDLE. Expect one stall cycle, after which 0x10 misses. A flush pulsed during FETCH is applied after FILL, so the next access to that line misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the two-way read-only instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FILL
    } state_t;

    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_W         = 128;

    // Number of index bits needed to address SETS sets (SETS is a power of two).
    function automatic int idx_width(input int sets);
        int w;
        w = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((1 << i) < sets) w = int'(i) + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid/tag/data arrays, combinational lookup, synchronous line fill.
module icache_way
    import icache_pkg::*;
#(
    parameter  int SETS  = 8,
    parameter  int TAG_W = 25,
    localparam int IDX_W = idx_width(SETS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  tag,
    input  logic [1:0]        off,
    input  logic [LINE_W-1:0] line_in,
    output logic              hit,
    output logic              valid,
    output logic [31:0]       word
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    // Only valid bits are cleared; tag/data keep whatever they held.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= line_in;
        end
    end

    assign valid = valid_q[idx];
    assign hit   = valid_q[idx] && (tag_q[idx] == tag);
    assign word  = data_q[idx][32*off +: 32];

endmodule

// File: rtl/icache_2way_ro.sv
// Two-way set-associative read-only instruction cache with per-set LRU.
// Optional whole-cache flush port enabled by defining ICACHE_FLUSH_EN.
module icache_2way_ro
    import icache_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int SETS   = 8
) (
    input  logic              clk,
    input  logic              proc_reset,
`ifdef ICACHE_FLUSH_EN
    input  logic              proc_flush,
`endif
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic [31:0]       proc_rdata,
    output logic              proc_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready
);

    localparam int IDX_W = idx_width(SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    state_t state, state_nx;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       off;
    logic [SETS-1:0]  lru;

    logic        hit0, hit1, v0, v1;
    logic [31:0] w0, w1;
    logic        fill_we, victim, lru_we, lru_val, clr_all, flush_now;
    logic        unused_inputs;

    assign off       = proc_addr[1:0];
    assign idx       = proc_addr[IDX_W+1:2];
    assign tag       = proc_addr[ADDR_W-1:IDX_W+2];
    assign mem_addr  = proc_addr[ADDR_W-1:2];
    assign mem_write = 1'b0;
    assign mem_wdata = '0;

    assign unused_inputs = ^{proc_write, proc_wdata};

`ifdef ICACHE_FLUSH_EN
    logic flush_pend;

    // A flush seen while busy is held until the fill has finished.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            flush_pend <= 1'b0;
        end else if (state != IDLE) begin
            if (proc_flush) flush_pend <= 1'b1;
        end else begin
            flush_pend <= 1'b0;
        end
    end

    assign flush_now = (state == IDLE) && (proc_flush || flush_pend);
`else
    assign flush_now = 1'b0;
`endif

    assign clr_all = proc_reset || flush_now;
    assign victim  = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[idx]);

    icache_way #(.SETS(SETS), .TAG_W(TAG_W)) u_way0 (
        .clk     (clk),
        .clr     (clr_all),
        .we      (fill_we && !victim),
        .idx     (idx),
        .tag     (tag),
        .off     (off),
        .line_in (mem_rdata),
        .hit     (hit0),
        .valid   (v0),
        .word    (w0)
    );

    icache_way #(.SETS(SETS), .TAG_W(TAG_W)) u_way1 (
        .clk     (clk),
        .clr     (clr_all),
        .we      (fill_we && victim),
        .idx     (idx),
        .tag     (tag),
        .off     (off),
        .line_in (mem_rdata),
        .hit     (hit1),
        .valid   (v1),
        .word    (w1)
    );

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_all) begin
            lru <= '0;
        end else if (lru_we) begin
            lru[idx] <= lru_val;
        end
    end

    always_comb begin
        state_nx   = state;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        fill_we    = 1'b0;
        lru_we     = 1'b0;
        lru_val    = 1'b0;
        case (state)
            IDLE: begin
                if (flush_now) begin
                    proc_stall = 1'b1;
                end else if (proc_read) begin
                    if (hit0 || hit1) begin
                        // Way 0 wins a double hit; LRU then points at way 1.
                        proc_rdata = hit0 ? w0 : w1;
                        lru_we     = 1'b1;
                        lru_val    = hit0;
                    end else begin
                        proc_stall = 1'b1;
                        state_nx   = FETCH;
                    end
                end
            end
            FETCH: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                if (mem_ready) begin
                    fill_we  = 1'b1;
                    lru_we   = 1'b1;
                    lru_val  = ~victim;
                    state_nx = FILL;
                end
            end
            FILL: begin
                proc_stall = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Reset overrides everything: abort any fetch and write nothing.
        if (proc_reset) begin
            state_nx   = IDLE;
            proc_stall = 1'b1;
            proc_rdata = '0;
            mem_read   = 1'b0;
            fill_we    = 1'b0;
            lru_we     = 1'b0;
        end
    end

endmodule

// File: tb/tb_icache_2way_ro.sv
// Directed scoreboard bench for icache_2way_ro (SETS=8, ADDR_W=30).
module tb_icache_2way_ro;

    logic         clk = 1'b0;
    logic         proc_reset = 1'b1;
`ifdef ICACHE_FLUSH_EN
    logic         proc_flush = 1'b0;
`endif
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata = '0;
    logic [127:0] mem_wdata;
    logic         mem_ready = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    icache_2way_ro #(.ADDR_W(30), .SETS(8)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
`ifdef ICACHE_FLUSH_EN
        .proc_flush (proc_flush),
`endif
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready)
    );

    function automatic logic [31:0] model(input logic [29:0] a);
        return {4'hC, a[21:2], 6'h00, a[1:0]};
    endfunction

    function automatic logic [127:0] line(input logic [27:0] la);
        logic [127:0] l;
        logic [1:0]   kk;
        l = '0;
        for (int k = 0; k < 4; k++) begin
            kk = 2'(k);
            l[32*k +: 32] = {4'hC, la[19:0], 6'h00, kk};
        end
        return l;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold a read until the cache returns data, acting as the line memory.
    task automatic read_word(input string tag, input logic [29:0] addr, input int lat,
                             input int exp_stall, input int exp_fetch, input bit flush_in_fetch);
        int stalls, fetches, bcnt;
        bit done;
        logic [31:0] e;
        stalls = 0; fetches = 0; bcnt = 0; done = 1'b0;
        proc_read = 1'b1;
        proc_addr = addr;
        exp_q.push_back(model(addr));
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_read) begin
                fetches++;
                bcnt++;
                if (bcnt == 1) check({tag, "_maddr"}, 128'(mem_addr), 128'(addr[29:2]));
                mem_rdata = line(mem_addr);
                mem_ready = (bcnt == lat);
            end else begin
                bcnt = 0;
            end
`ifdef ICACHE_FLUSH_EN
            proc_flush = flush_in_fetch && mem_read && (fetches == 1);
`endif
            if (proc_stall) begin
                stalls++;
            end else begin
                done = 1'b1;
                if (exp_q.size() == 0) begin
                    check({tag, "_sb_empty"}, 128'(proc_rdata), 128'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_data"}, 128'(proc_rdata), 128'(e));
                end
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            check({tag, "_timeout"}, 128'(done), 128'd1);
            void'(exp_q.pop_front());
        end
        check({tag, "_stalls"}, 128'(stalls), 128'(exp_stall));
        check({tag, "_fetch"}, 128'(fetches), 128'(exp_fetch));
        proc_read = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        // Reset behaviour
        repeat (2) begin
            @(negedge clk);
            check("rst_stall", 128'(proc_stall), 128'd1);
            check("rst_mread", 128'(mem_read), 128'd0);
            check("rst_mwrite", 128'(mem_write), 128'd0);
            check("rst_wdata", mem_wdata, 128'd0);
        end
        @(posedge clk); #1;
        proc_reset = 1'b0;
        @(negedge clk);
        check("idle_stall", 128'(proc_stall), 128'd0);
        @(posedge clk); #1;

        // Cold miss then hits in the same line
        read_word("cold", 30'h10, 3, 5, 3, 1'b0);
        read_word("hit11", 30'h11, 1, 0, 0, 1'b0);
        read_word("hit10", 30'h10, 1, 0, 0, 1'b0);

        // Second way in the same set, then alternate
        read_word("miss30", 30'h30, 2, 4, 2, 1'b0);
        read_word("alt10", 30'h10, 1, 0, 0, 1'b0);
        read_word("alt30", 30'h30, 1, 0, 0, 1'b0);
        read_word("alt13", 30'h13, 1, 0, 0, 1'b0);
        read_word("alt32", 30'h32, 1, 0, 0, 1'b0);

        // LRU eviction: touch 0x10, then 0x50 must replace 0x30
        read_word("lru10", 30'h10, 1, 0, 0, 1'b0);
        read_word("miss50", 30'h50, 1, 3, 1, 1'b0);
        read_word("keep10", 30'h12, 1, 0, 0, 1'b0);
        read_word("hit51", 30'h51, 1, 0, 0, 1'b0);
        read_word("evict30", 30'h31, 4, 6, 4, 1'b0);

        // Idle cycles with writes attempted
        proc_write = 1'b1;
        for (int i = 0; i < 10; i++) begin
            proc_wdata = $urandom;
            proc_addr  = 30'($urandom);
            @(negedge clk);
            check("wr_stall", 128'(proc_stall), 128'd0);
            check("wr_mread", 128'(mem_read), 128'd0);
            check("wr_mwrite", 128'(mem_write), 128'd0);
            check("wr_rdata", 128'(proc_rdata), 128'd0);
            @(posedge clk); #1;
        end
        proc_write = 1'b0;

        // Reset on the second FETCH cycle, followed by a stale mem_ready
        proc_read = 1'b1;
        proc_addr = 30'h84;
        @(negedge clk);
        check("rf_miss", 128'(proc_stall), 128'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rf_fetch1", 128'(mem_read), 128'd1);
        @(posedge clk); #1;
        proc_reset = 1'b1;
        mem_ready  = 1'b1;
        mem_rdata  = line(28'h21);
        @(negedge clk);
        check("rf_rst_mread", 128'(mem_read), 128'd0);
        check("rf_rst_stall", 128'(proc_stall), 128'd1);
        @(posedge clk); #1;
        proc_reset = 1'b0;
        proc_read  = 1'b0;
        @(negedge clk);
        check("rf_post_mread", 128'(mem_read), 128'd0);
        check("rf_post_stall", 128'(proc_stall), 128'd0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        read_word("rf_reread", 30'h84, 2, 4, 2, 1'b0);

`ifdef ICACHE_FLUSH_EN
        // Flush in IDLE, then flush raised during FETCH
        read_word("fl_fill", 30'h10, 1, 3, 1, 1'b0);
        proc_flush = 1'b1;
        @(negedge clk);
        check("fl_stall", 128'(proc_stall), 128'd1);
        check("fl_mread", 128'(mem_read), 128'd0);
        @(posedge clk); #1;
        proc_flush = 1'b0;
        read_word("fl_miss", 30'h10, 1, 3, 1, 1'b0);
        read_word("fl_busy", 30'h20, 2, 9, 4, 1'b1);
        proc_flush = 1'b0;
        read_word("fl_after", 30'h10, 1, 3, 1, 1'b0);
`endif

        check("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
